// File: rtl/jtag_reg_pkg.sv
// Shared opcode and FSM state types for the JTAG register bank.
package jtag_reg_pkg;

  typedef enum logic [1:0] {
    OP_READ_LIVE = 2'b00,
    OP_WRITE     = 2'b01,
    OP_SNAPSHOT  = 2'b10,
    OP_READ_SNAP = 2'b11
  } cmdOp_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } fsmState_t;

endpackage

// File: rtl/jtag_reg_slice.sv
// One channel: user-visible output register with write strobe, plus snapshot shadow.
module jtag_reg_slice #(
  parameter int                WIDTH       = 32,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wrEn,
  input  logic             snapEn,
  input  logic [WIDTH-1:0] wrData,
  input  logic [WIDTH-1:0] liveIn,
  output logic [WIDTH-1:0] dataOut,
  output logic [WIDTH-1:0] shadowOut,
  output logic             update
);

  // Strobe is registered alongside the data so it marks the first cycle of the new value.
  always_ff @(posedge clk) begin
    if (reset) begin
      dataOut   <= RESET_VALUE;
      shadowOut <= '0;
      update    <= 1'b0;
    end else begin
      update <= wrEn;
      if (wrEn)   dataOut   <= wrData;
      if (snapEn) shadowOut <= liveIn;
    end
  end

endmodule

// File: rtl/jtag_reg_bank.sv
// Addressed register bank behind the JTAG deserialiser: read-live, write,
// coherent snapshot and read-snapshot commands with a valid/ready handshake.
module jtag_reg_bank
  import jtag_reg_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               NUM_REGS    = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               ADDR_W      = 8
) (
  input  logic                      iMAIN_CLK,
  input  logic                      iRESET,
  input  logic                      iCMD_VALID,
  output logic                      oCMD_READY,
  input  logic [1:0]                iCMD_OP,
  input  logic [ADDR_W-1:0]         iCMD_ADDR,
  input  logic [WIDTH-1:0]          iCMD_WDATA,
  output logic                      oRSP_VALID,
  input  logic                      iRSP_READY,
  output logic [WIDTH-1:0]          oRSP_DATA,
  output logic                      oRSP_ERR,
  input  logic [NUM_REGS*WIDTH-1:0] iDATA,
  output logic [NUM_REGS*WIDTH-1:0] oDATA,
  output logic [NUM_REGS-1:0]       oUPDATE,
  output logic [1:0]                oSTATE
);

  fsmState_t           state;
  cmdOp_t              opReg;
  logic [ADDR_W-1:0]   addrReg;
  logic [WIDTH-1:0]    wdataReg;
  logic                inRange;
  logic                execWrite;
  logic                execSnap;
  logic [WIDTH-1:0]    liveWord;
  logic [WIDTH-1:0]    snapWord;
  logic [WIDTH-1:0]    shadow [NUM_REGS];
  logic [NUM_REGS-1:0] wrEn;

  // Handshakes: a command transfers on an edge where iCMD_VALID && oCMD_READY;
  // a response transfers on an edge where oRSP_VALID && iRSP_READY. Response
  // data and error stay stable while oRSP_VALID is high and not yet taken.
  assign oCMD_READY = (state == S_IDLE) && !iRESET;
  assign oSTATE     = state;

  // Zero-extended compare: addresses never wrap onto a real channel.
  assign inRange   = {1'b0, addrReg} < (ADDR_W+1)'(NUM_REGS);
  assign execWrite = (state == S_EXEC) && (opReg == OP_WRITE);
  assign execSnap  = (state == S_EXEC) && (opReg == OP_SNAPSHOT);

  always_comb begin
    liveWord = '0;
    snapWord = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (addrReg == ADDR_W'(k)) begin
        liveWord = iDATA[k*WIDTH +: WIDTH];
        snapWord = shadow[k];
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : gSlice
    assign wrEn[k] = execWrite && (addrReg == ADDR_W'(k));

    jtag_reg_slice #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) uSlice (
      .clk       (iMAIN_CLK),
      .reset     (iRESET),
      .wrEn      (wrEn[k]),
      .snapEn    (execSnap),
      .wrData    (wdataReg),
      .liveIn    (iDATA[k*WIDTH +: WIDTH]),
      .dataOut   (oDATA[k*WIDTH +: WIDTH]),
      .shadowOut (shadow[k]),
      .update    (oUPDATE[k])
    );
  end

  always_ff @(posedge iMAIN_CLK) begin
    if (iRESET) begin
      state      <= S_IDLE;
      opReg      <= OP_READ_LIVE;
      addrReg    <= '0;
      wdataReg   <= '0;
      oRSP_VALID <= 1'b0;
      oRSP_DATA  <= '0;
      oRSP_ERR   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (iCMD_VALID) begin
            opReg    <= cmdOp_t'(iCMD_OP);
            addrReg  <= iCMD_ADDR;
            wdataReg <= iCMD_WDATA;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          oRSP_VALID <= 1'b1;
          state      <= S_RESP;
          case (opReg)
            OP_READ_LIVE: begin
              oRSP_DATA <= inRange ? liveWord : '0;
              oRSP_ERR  <= !inRange;
            end
            OP_WRITE: begin
              oRSP_DATA <= inRange ? wdataReg : '0;
              oRSP_ERR  <= !inRange;
            end
            OP_SNAPSHOT: begin
              oRSP_DATA <= '0;
              oRSP_ERR  <= 1'b0;
            end
            OP_READ_SNAP: begin
              oRSP_DATA <= inRange ? snapWord : '0;
              oRSP_ERR  <= !inRange;
            end
            default: begin
              oRSP_DATA <= '0;
              oRSP_ERR  <= 1'b0;
            end
          endcase
        end
        S_RESP: begin
          if (iRSP_READY) begin
            oRSP_VALID <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
